// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : EX-stage multiply/divide unit. Runs MULT/MULTU/DIV/DIVU as
//                multicycle operations, holds the architectural HI/LO
//                registers and handles MTHI/MTLO. Defining MDU_MADD_EN enables
//                the MADD/MADDU/MSUB/MSUBU accumulate ops (7-10). When it is
//                undefined, those codes behave as NOP.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_cnt_w      = $clog2(c_max_cycles + 1);

  localparam logic [3:0] c_op_mult  = 4'd1;
  localparam logic [3:0] c_op_multu = 4'd2;
  localparam logic [3:0] c_op_div   = 4'd3;
  localparam logic [3:0] c_op_divu  = 4'd4;
  localparam logic [3:0] c_op_mthi  = 4'd5;
  localparam logic [3:0] c_op_mtlo  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] c_op_madd  = 4'd7;
  localparam logic [3:0] c_op_maddu = 4'd8;
  localparam logic [3:0] c_op_msub  = 4'd9;
  localparam logic [3:0] c_op_msubu = 4'd10;
`endif

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q,   cnt_d;
  logic [31:0]          a_q,     a_d;
  logic [31:0]          b_q,     b_d;
  logic [3:0]           op_q,    op_d;
  logic [31:0]          hi_q,    hi_d;
  logic [31:0]          lo_q,    lo_d;

  // Datapath results are computed combinationally from the latched operands;
  // only the commit into HI/LO waits for the counter to expire.
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_a_abs;
  logic [31:0] w_b_abs;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_div_q;
  logic [31:0] w_div_r;
  logic [31:0] w_divu_q;
  logic [31:0] w_divu_r;

  // Sign-extended 64x64 product keeps the low 64 bits equal to the signed product.
  assign w_prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign w_prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide via magnitudes: quotient truncates toward zero, remainder
  // follows the dividend. 0x80000000 / -1 naturally wraps to 0x80000000.
  assign w_a_abs  = a_q[31] ? (~a_q + 32'd1) : a_q;
  assign w_b_abs  = b_q[31] ? (~b_q + 32'd1) : b_q;
  assign w_q_mag  = w_a_abs / w_b_abs;
  assign w_r_mag  = w_a_abs % w_b_abs;
  assign w_div_q  = (a_q[31] ^ b_q[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_div_r  = a_q[31] ? (~w_r_mag + 32'd1) : w_r_mag;
  assign w_divu_q = a_q / b_q;
  assign w_divu_r = a_q % b_q;

`ifdef MDU_MADD_EN
  logic [63:0] w_acc_add_s;
  logic [63:0] w_acc_add_u;
  logic [63:0] w_acc_sub_s;
  logic [63:0] w_acc_sub_u;

  assign w_acc_add_s = {hi_q, lo_q} + w_prod_s;
  assign w_acc_add_u = {hi_q, lo_q} + w_prod_u;
  assign w_acc_sub_s = {hi_q, lo_q} - w_prod_s;
  assign w_acc_sub_u = {hi_q, lo_q} - w_prod_u;
`endif

  // Next-state logic: accept ops while idle, count down while running, commit on the last cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (op)
            c_op_mult, c_op_multu
`ifdef MDU_MADD_EN
            , c_op_madd, c_op_maddu, c_op_msub, c_op_msubu
`endif
            : begin
              state_d = S_RUN;
              cnt_d   = c_cnt_w'(MULT_CYCLES);
              a_d     = A;
              b_d     = B;
              op_d    = op;
            end
            c_op_div, c_op_divu: begin
              state_d = S_RUN;
              cnt_d   = c_cnt_w'(DIV_CYCLES);
              a_d     = A;
              b_d     = B;
              op_d    = op;
            end
            c_op_mthi: hi_d = A;
            c_op_mtlo: lo_d = A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - c_cnt_w'(1);
        if (cnt_q == c_cnt_w'(1)) begin
          state_d = S_IDLE;
          case (op_q)
            c_op_mult:  {hi_d, lo_d} = w_prod_s;
            c_op_multu: {hi_d, lo_d} = w_prod_u;
            c_op_div:   if (b_q != 32'd0) {hi_d, lo_d} = {w_div_r, w_div_q};
            c_op_divu:  if (b_q != 32'd0) {hi_d, lo_d} = {w_divu_r, w_divu_q};
`ifdef MDU_MADD_EN
            c_op_madd:  {hi_d, lo_d} = w_acc_add_s;
            c_op_maddu: {hi_d, lo_d} = w_acc_add_u;
            c_op_msub:  {hi_d, lo_d} = w_acc_sub_s;
            c_op_msubu: {hi_d, lo_d} = w_acc_sub_u;
`endif
            default: ;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Self-checking bench for mult_div_unit. Directed cases plus
//                random ops compared against a behavioural HI/LO model.
//                Define MDU_MADD_EN for both DUT and bench to cover ops 7-10.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  op    = 4'd0;
  logic [31:0] A     = 32'd0;
  logic [31:0] B     = 32'd0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .flush (flush),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Number of busy cycles an accepted op produces.
  function automatic int latency(input logic [3:0] o);
    case (o)
      4'd1, 4'd2: return MULT_N;
      4'd3, 4'd4: return DIV_N;
`ifdef MDU_MADD_EN
      4'd7, 4'd8, 4'd9, 4'd10: return MULT_N;
`endif
      default: return 0;
    endcase
  endfunction

  // Architectural effect of an op on the model HI/LO.
  task automatic model_apply(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa  = longint'($signed(a));
    longint      sb  = longint'($signed(b));
    longint      ps  = sa * sb;
    logic [63:0] pu  = 64'(a) * 64'(b);
    logic [63:0] acc = {hi_m, lo_m};
    case (o)
      4'd1: {hi_m, lo_m} = 64'(ps);
      4'd2: {hi_m, lo_m} = pu;
      4'd3: if (b != 0) begin
        lo_m = 32'(sa / sb);
        hi_m = 32'(sa % sb);
      end
      4'd4: if (b != 0) begin
        lo_m = a / b;
        hi_m = a % b;
      end
      4'd5: hi_m = a;
      4'd6: lo_m = a;
`ifdef MDU_MADD_EN
      4'd7:  {hi_m, lo_m} = acc + 64'(ps);
      4'd8:  {hi_m, lo_m} = acc + pu;
      4'd9:  {hi_m, lo_m} = acc - 64'(ps);
      4'd10: {hi_m, lo_m} = acc - pu;
`endif
      default: ;
    endcase
  endtask

  // Issue one op, check busy for its whole duration, then check HI/LO.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic fl);
    int          n;
    logic [31:0] old_hi = hi_m;
    logic [31:0] old_lo = lo_m;
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b; flush = fl;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0; op = 4'd0; A = $urandom; B = $urandom;
    n = fl ? 0 : latency(o);
    if (!fl) model_apply(o, a, b);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq($sformatf("busy_run op%0d cyc%0d", o, i), {31'd0, busy}, 32'd1);
      check_eq($sformatf("hi_hold op%0d", o), hi, old_hi);
      check_eq($sformatf("lo_hold op%0d", o), lo, old_lo);
      flush = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    flush = 1'b0;
    check_eq($sformatf("busy_done op%0d", o), {31'd0, busy}, 32'd0);
    check_eq($sformatf("hi op%0d a=%08h b=%08h", o, a, b), hi, hi_m);
    check_eq($sformatf("lo op%0d a=%08h b=%08h", o, a, b), lo, lo_m);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    repeat (2) @(negedge clk);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_hi", hi, 32'd0);
    check_eq("reset_lo", lo, 32'd0);
    reset = 1'b0;

    run_op(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    check_eq("mult_neg_hi", hi, 32'hFFFFFFFF);
    check_eq("mult_neg_lo", lo, 32'hFFFFFFFA);
    run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check_eq("multu_max_hi", hi, 32'hFFFFFFFE);
    check_eq("multu_max_lo", lo, 32'h00000001);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    check_eq("div_neg_lo", lo, 32'hFFFFFFFD);
    check_eq("div_neg_hi", hi, 32'hFFFFFFFF);
    run_op(4'd4, 32'd7, 32'd0, 1'b0);
    check_eq("divu_zero_lo", lo, 32'hFFFFFFFD);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check_eq("div_ovf_lo", lo, 32'h80000000);
    check_eq("div_ovf_hi", hi, 32'h00000000);
    run_op(4'd5, 32'h12345678, 32'd0, 1'b0);
    run_op(4'd6, 32'h00000009, 32'd0, 1'b0);
    check_eq("mthi_val", hi, 32'h12345678);
    check_eq("mtlo_val", lo, 32'h00000009);
    run_op(4'd1, 32'd100, 32'd100, 1'b1);
    check_eq("flush_hi", hi, 32'h12345678);

    run_op(4'd5, 32'd0, 32'd0, 1'b0);
    run_op(4'd6, 32'hFFFFFFFF, 32'd0, 1'b0);
    run_op(4'd8, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
    check_eq("maddu_hi", hi, 32'd1);
    check_eq("maddu_lo", lo, 32'd0);
`else
    check_eq("maddu_off_hi", hi, 32'd0);
    check_eq("maddu_off_lo", lo, 32'hFFFFFFFF);
`endif

    for (int k = 0; k < 80; k++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 15) == 0) begin
        ra = 32'h80000000;
        rb = 32'hFFFFFFFF;
      end
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      run_op(ro, ra, rb, ($urandom_range(0, 9) == 0));
    end

    // Reset during busy cycle 3 must clear everything immediately.
    @(negedge clk);
    start = 1'b1; op = 4'd1; A = 32'h00010001; B = 32'h00030003;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_reset_busy", {31'd0, busy}, 32'd0);
    check_eq("async_reset_hi", hi, 32'd0);
    check_eq("async_reset_lo", lo, 32'd0);
    hi_m = 32'd0;
    lo_m = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    run_op(4'd2, 32'd6, 32'd7, 1'b0);
    check_eq("post_reset_lo", lo, 32'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
